hazard_flush_ctrl: RTL and testbench
====================================

HAZARD_FLUSH_CTRL -- requirements
Module: hazard_flush_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 1, extra fetch-kill cycles after a taken branch (legal 0..7).
REQ-002 Parameter CNT_W, default 16, width of the performance counters.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 id_rs, id_rt  in  5 each  source registers of the instruction in ID.
REQ-006 id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt.
REQ-007 ex_mem_read  in  1  instruction in EX is a load.
REQ-008 ex_rd  in  5  destination register of the EX instruction.
REQ-009 branch_taken_ex  in  1  branch resolved taken in EX this cycle.
REQ-010 jump_id  in  1  unconditional jump decoded in ID this cycle.
REQ-011 kill_if  out  1  drives control_kill of the IF/ID instruction-kill mux (NOP insert).
REQ-012 kill_id  out  1  inserts bubble (NOP) into ID/EX.
REQ-013 pc_stall, ifid_stall  out  1 each  hold PC / hold IF/ID register.
REQ-014 state  out  2  FSM state: RUN=0, FLUSH=1.
REQ-015 kill_cnt, stall_cnt  out  CNT_W each  saturating counts of kill_if cycles / stall cycles.

Function
REQ-016 Load-use hazard (lu) SHALL be: ex_mem_read & ex_rd!=0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
REQ-017 Outputs kill_if, kill_id, pc_stall, ifid_stall SHALL be combinational from state, flush counter and current inputs (same-cycle response, zero latency).
REQ-018 RUN, branch_taken_ex=1: kill_if=1, kill_id=1, pc_stall=0, ifid_stall=0; if FLUSH_CYCLES>0 next state FLUSH with counter loaded FLUSH_CYCLES, else stay RUN.
REQ-019 RUN, no branch, lu=1: pc_stall=1, ifid_stall=1, kill_id=1, kill_if=0; stay RUN (one-cycle stall).
REQ-020 RUN, no branch, lu=0, jump_id=1: kill_if=1 only; stay RUN.
REQ-021 RUN, no event: all four outputs 0.
REQ-022 FLUSH: kill_if=1, pc_stall=0, ifid_stall=0, kill_id=0; counter decrements each cycle; return to RUN on the cycle counter reaches 0 after decrement (total FLUSH_CYCLES cycles in FLUSH).
REQ-023 FLUSH, branch_taken_ex=1: kill_id=1 additionally, counter reloaded to FLUSH_CYCLES, remain FLUSH.
REQ-024 FLUSH: jump_id and lu SHALL be ignored (the ID instruction is a killed NOP).
REQ-025 Priority SHALL be branch_taken_ex > lu > jump_id; lu and jump_id together give the lu response only (jump re-decoded next cycle).
REQ-026 kill_cnt SHALL increment on every cycle kill_if=1; stall_cnt on every cycle pc_stall=1; both saturate at 2^CNT_W-1, no wrap.
REQ-027 No X SHALL appear on any output when inputs are known.

Reset
REQ-028 reset_n=0 SHALL immediately force state=RUN, flush counter=0, kill_cnt=0, stall_cnt=0, independent of clk.
REQ-029 While reset_n=0, kill_if, kill_id, pc_stall, ifid_stall SHALL be 0.
REQ-030 Reset asserted mid-FLUSH SHALL abandon the flush; first cycle after release is RUN with no kill.

Verification
REQ-031 lu: ex_mem_read=1, ex_rd=5, id_rs=5, id_uses_rs=1 one cycle -> pc_stall=ifid_stall=kill_id=1 that cycle, stall_cnt=1, next cycle all 0.
REQ-032 ex_rd=0 with matching id_rs=0 and load -> no stall.
REQ-033 FLUSH_CYCLES=2, branch_taken_ex pulse at cycle N -> kill_if=1 at N, N+1, N+2, kill_id=1 at N only, state RUN at N+3, kill_cnt=3.
REQ-034 branch_taken_ex and lu and jump_id same cycle -> branch response only, stall_cnt unchanged.
REQ-035 Second branch_taken_ex during FLUSH -> counter reload, FLUSH extended by FLUSH_CYCLES from that cycle.
REQ-036 kill_cnt preloaded near saturation (CNT_W=4, 15 kills) then more kills -> holds 15; reset_n pulse mid-FLUSH -> counters 0, state RUN asynchronously.

Source files
------------

// File: rtl/hazard_flush_ctrl.sv
// hazard_flush_ctrl: load-use stall, branch/jump fetch-kill control with
// a multi-cycle post-branch flush FSM and saturating kill/stall counters.
module hazard_flush_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [4:0]       i_id_rs,
    input  logic [4:0]       i_id_rt,
    input  logic             i_id_uses_rs,
    input  logic             i_id_uses_rt,
    input  logic             i_ex_mem_read,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_branch_taken_ex,
    input  logic             i_jump_id,
    output logic             o_kill_if,
    output logic             o_kill_id,
    output logic             o_pc_stall,
    output logic             o_ifid_stall,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_kill_cnt,
    output logic [CNT_W-1:0] o_stall_cnt
);
    typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1} state_t;

    localparam logic [2:0] FC = 3'(FLUSH_CYCLES);

    state_t           r_state;
    logic [2:0]       r_fcnt;
    logic [CNT_W-1:0] r_kill_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_lu;
    logic             w_flush;
    logic             w_kill_if;
    logic             w_kill_id;
    logic             w_stall;

    assign w_lu = i_ex_mem_read && (i_ex_rd != 5'd0) &&
                  ((i_id_uses_rs && (i_id_rs == i_ex_rd)) ||
                   (i_id_uses_rt && (i_id_rt == i_ex_rd)));
    assign w_flush = (r_state == FLUSH);

    // During FLUSH the ID slot holds a killed NOP, so lu and jump are ignored.
    always_comb begin
        w_kill_if = i_branch_taken_ex || w_flush || (!w_lu && i_jump_id);
        w_kill_id = i_branch_taken_ex || (!w_flush && w_lu);
        w_stall   = !i_branch_taken_ex && !w_flush && w_lu;
    end

    assign o_kill_if    = i_reset_n & w_kill_if;
    assign o_kill_id    = i_reset_n & w_kill_id;
    assign o_pc_stall   = i_reset_n & w_stall;
    assign o_ifid_stall = i_reset_n & w_stall;
    assign o_state      = r_state;
    assign o_kill_cnt   = r_kill_cnt;
    assign o_stall_cnt  = r_stall_cnt;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= RUN;
            r_fcnt      <= 3'd0;
            r_kill_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (i_branch_taken_ex) begin
                if (FC != 3'd0) begin
                    r_state <= FLUSH;
                    r_fcnt  <= FC;
                end
            end else if (w_flush) begin
                r_fcnt <= r_fcnt - 3'd1;
                if (r_fcnt == 3'd1) r_state <= RUN;
            end
            if (w_kill_if && (r_kill_cnt != '1)) r_kill_cnt <= r_kill_cnt + 1'b1;
            if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// tb_hazard_flush_ctrl: directed and random stimulus checked against a
// cycle-level behavioural model of the hazard/flush rules.
module tb_hazard_flush_ctrl;
    localparam int FC    = 2;
    localparam int CW    = 4;
    localparam int SAT   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    id_rs = '0, id_rt = '0, ex_rd = '0;
    logic          uses_rs = 1'b0, uses_rt = 1'b0, mem_read = 1'b0;
    logic          br = 1'b0, jmp = 1'b0;
    logic          kill_if, kill_id, pc_stall, ifid_stall;
    logic [1:0]    state;
    logic [CW-1:0] kill_cnt, stall_cnt;

    int checks = 0;
    int failures = 0;
    int rem = 0, kc = 0, sc = 0;

    hazard_flush_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_id_rs(id_rs), .i_id_rt(id_rt),
        .i_id_uses_rs(uses_rs), .i_id_uses_rt(uses_rt),
        .i_ex_mem_read(mem_read), .i_ex_rd(ex_rd),
        .i_branch_taken_ex(br), .i_jump_id(jmp),
        .o_kill_if(kill_if), .o_kill_id(kill_id),
        .o_pc_stall(pc_stall), .o_ifid_stall(ifid_stall),
        .o_state(state), .o_kill_cnt(kill_cnt), .o_stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, then advance it.
    task automatic step(input logic b, input logic j, input logic mr, input logic urs,
                        input logic urt, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd);
        bit lu, in_flush, e_kif, e_kid, e_st;
        int n_rem;
        @(negedge clk);
        br = b; jmp = j; mem_read = mr; uses_rs = urs; uses_rt = urt;
        id_rs = rs; id_rt = rt; ex_rd = rd;
        #1;
        lu = mr && rd != 0 && ((urs && rs == rd) || (urt && rt == rd));
        in_flush = rem > 0;
        e_kif = 0; e_kid = 0; e_st = 0; n_rem = rem;
        if (b) begin
            e_kif = 1; e_kid = 1; n_rem = FC;
        end else if (in_flush) begin
            e_kif = 1; n_rem = rem - 1;
        end else if (lu) begin
            e_kid = 1; e_st = 1;
        end else if (j) begin
            e_kif = 1;
        end
        chk("kill_if", 32'(kill_if), 32'(e_kif));
        chk("kill_id", 32'(kill_id), 32'(e_kid));
        chk("pc_stall", 32'(pc_stall), 32'(e_st));
        chk("ifid_stall", 32'(ifid_stall), 32'(e_st));
        chk("state", 32'(state), in_flush ? 32'd1 : 32'd0);
        chk("kill_cnt", 32'(kill_cnt), 32'(kc));
        chk("stall_cnt", 32'(stall_cnt), 32'(sc));
        @(posedge clk);
        rem = n_rem;
        if (e_kif && kc < SAT) kc++;
        if (e_st && sc < SAT) sc++;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reset asserted mid-cycle, away from any clock edge, with inputs still live.
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_kill_if", 32'(kill_if), 0);
        chk("rst_kill_id", 32'(kill_id), 0);
        chk("rst_pc_stall", 32'(pc_stall), 0);
        chk("rst_ifid_stall", 32'(ifid_stall), 0);
        chk("rst_state", 32'(state), 0);
        chk("rst_kill_cnt", 32'(kill_cnt), 0);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        rem = 0; kc = 0; sc = 0;
        br = 0; jmp = 0; mem_read = 0; uses_rs = 0; uses_rt = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        br = 1'b1; mem_read = 1'b1; uses_rs = 1'b1; id_rs = 5'd5; ex_rd = 5'd5;
        do_reset();
        // Load-use stall, then clear next cycle.
        step(0, 0, 1, 1, 0, 5, 0, 5);
        idle();
        step(0, 0, 1, 0, 1, 0, 9, 9);
        // Load to r0 never stalls.
        step(0, 0, 1, 1, 1, 0, 0, 0);
        // lu and jump together: lu only.
        step(0, 1, 1, 1, 0, 3, 0, 3);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        do_reset();
        // Branch with lu and jump: branch response, FLUSH for FC cycles.
        step(1, 1, 1, 1, 0, 5, 0, 5);
        step(0, 1, 1, 1, 0, 5, 0, 5);
        idle();
        #1 chk("branch_kill_total", 32'(kill_cnt), 3);
        chk("branch_no_stall", 32'(stall_cnt), 0);
        idle();
        // Second branch inside FLUSH extends it.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle();
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle();
        idle();
        idle();
        // Saturation of kill_cnt.
        for (int i = 0; i < SAT + 5; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
        #1 chk("kill_sat", 32'(kill_cnt), SAT);
        // Reset mid-FLUSH abandons the flush.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        idle();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else step($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
